// File: rtl/pool_ctrl_pkg.sv
// Shared definitions for the pooling stage (and the conv controller next to it).
// Holds the DRAM region map, the {chnl, y, x} plane field widths, the plane
// offset payload struct and the one-hot pool FSM state encoding.
package pool_ctrl_pkg;

  // DRAM word-address width and region map.
  localparam int unsigned DRAM_AW = 18;
  localparam logic [DRAM_AW-1:0] PARAM_BASE = 18'd0;
  localparam logic [DRAM_AW-1:0] WTS_BASE   = 18'd64;
  localparam logic [DRAM_AW-1:0] IFMAP_BASE = 18'd65536;
  localparam logic [DRAM_AW-1:0] OFMAP_BASE = 18'd131072;

  // Plane address fields.
  localparam int unsigned CHNL_W  = 4;
  localparam int unsigned Y_W     = 5;
  localparam int unsigned X_W     = 5;
  localparam int unsigned PLANE_W = CHNL_W + Y_W + X_W;

  // Loop counter / size widths.
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned WIN_W   = 2;
  localparam int unsigned NCHNL_W = 5;
  localparam int unsigned FMAP_W  = 6;
  localparam int unsigned OUT_W   = 5;

  // Word offset inside the plane region.
  typedef struct packed {
    logic [CHNL_W-1:0] chnl;
    logic [Y_W-1:0]    y;
    logic [X_W-1:0]    x;
  } plane_off_t;

  // One-hot FSM bit indices.
  localparam int unsigned ST_IDLE = 0;
  localparam int unsigned ST_RD   = 1;
  localparam int unsigned ST_ACC  = 2;
  localparam int unsigned ST_WR   = 3;
  localparam int unsigned ST_DONE = 4;
  localparam int unsigned ST_NUM  = 5;

  typedef enum logic [ST_NUM-1:0] {
    S_IDLE = ST_NUM'(1 << ST_IDLE),
    S_RD   = ST_NUM'(1 << ST_RD),
    S_ACC  = ST_NUM'(1 << ST_ACC),
    S_WR   = ST_NUM'(1 << ST_WR),
    S_DONE = ST_NUM'(1 << ST_DONE)
  } pool_state_e;

endpackage

// File: rtl/pool_ctrl_if.sv
// DRAM access bundle for the pooling stage.
//   data_in    : read data, valid one cycle after its address
//   addr_in    : read address      dram_en_rd : read enable
//   addr_out   : write address     data_out   : write data
//   dram_en_wr : write enable
// master = pooling stage, slave = DRAM side.
interface pool_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 18
);

  logic [DATA_WIDTH-1:0] data_in;
  logic [ADDR_WIDTH-1:0] addr_in;
  logic                  dram_en_rd;
  logic [ADDR_WIDTH-1:0] addr_out;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  dram_en_wr;

  modport master (
    input  data_in,
    output addr_in, dram_en_rd, addr_out, data_out, dram_en_wr
  );

  modport slave (
    output data_in,
    input  addr_in, dram_en_rd, addr_out, data_out, dram_en_wr
  );

endinterface

// File: rtl/pool_addr_gen.sv
// Loop counters and address arithmetic for 2x2 stride-2 pooling.
// Ports:
//   clk, srst       : clock, synchronous active-high reset
//   start_i         : latch sizes and clear all counters
//   num_chnl_i      : channel count      out_h_i/out_w_i : pooled plane size
//   win_inc_i       : step to next window element (RD cycle)
//   adv_i           : step to next output pixel (WR cycle)
//   win_o           : current window element index (registered)
//   last_win_c_o    : current element is the 4th of the window
//   last_pix_c_o    : current pixel is the last of the last channel
//   src_addr_c_o    : read address for the next-cycle counter values
//   dst_addr_c_o    : write address for the next-cycle counter values
// Addresses come from the next-state counters so the caller can register them
// and have them line up with its own registered state.
module pool_addr_gen
  import pool_ctrl_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 18,
  parameter logic [ADDR_WIDTH-1:0] SRC_BASE   = ADDR_WIDTH'(OFMAP_BASE),
  parameter logic [ADDR_WIDTH-1:0] DST_BASE   = ADDR_WIDTH'(IFMAP_BASE)
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  start_i,
  input  logic [NCHNL_W-1:0]    num_chnl_i,
  input  logic [OUT_W-1:0]      out_h_i,
  input  logic [OUT_W-1:0]      out_w_i,
  input  logic                  win_inc_i,
  input  logic                  adv_i,
  output logic [WIN_W-1:0]      win_o,
  output logic                  last_win_c_o,
  output logic                  last_pix_c_o,
  output logic [ADDR_WIDTH-1:0] src_addr_c_o,
  output logic [ADDR_WIDTH-1:0] dst_addr_c_o
);

  logic [NCHNL_W-1:0] nchnl_q;
  logic [OUT_W-1:0]   out_h_q, out_w_q;
  logic [CNT_W-1:0]   chnl_q, chnl_d;
  logic [CNT_W-1:0]   py_q, py_d;
  logic [CNT_W-1:0]   px_q, px_d;
  logic [WIN_W-1:0]   win_q, win_d;
  logic               last_px_c, last_py_c, last_ch_c;
  plane_off_t         src_off_c, dst_off_c;

  // Loop-end flags; sizes are known to be non-zero whenever these matter.
  assign last_px_c    = ({1'b0, px_q} == OUT_W'(out_w_q - OUT_W'(1)));
  assign last_py_c    = ({1'b0, py_q} == OUT_W'(out_h_q - OUT_W'(1)));
  assign last_ch_c    = ({1'b0, chnl_q} == NCHNL_W'(nchnl_q - NCHNL_W'(1)));
  assign last_win_c_o = (win_q == WIN_W'(3));
  assign last_pix_c_o = last_px_c & last_py_c & last_ch_c;
  assign win_o        = win_q;

  // Next counter values: px inner, py middle, chnl outer.
  always_comb begin
    chnl_d = chnl_q;
    py_d   = py_q;
    px_d   = px_q;
    win_d  = win_q;
    if (start_i) begin
      chnl_d = '0;
      py_d   = '0;
      px_d   = '0;
      win_d  = '0;
    end else begin
      if (win_inc_i) begin
        win_d = WIN_W'(win_q + WIN_W'(1));
      end
      if (adv_i) begin
        if (last_px_c) begin
          px_d = '0;
          if (last_py_c) begin
            py_d   = '0;
            chnl_d = CNT_W'(chnl_q + CNT_W'(1));
          end else begin
            py_d = CNT_W'(py_q + CNT_W'(1));
          end
        end else begin
          px_d = CNT_W'(px_q + CNT_W'(1));
        end
      end
    end
  end

  // Window element order (0,0),(0,1),(1,0),(1,1): dy = win[1], dx = win[0].
  always_comb begin
    src_off_c = '{chnl: chnl_d, y: {py_d, win_d[1]}, x: {px_d, win_d[0]}};
    dst_off_c = '{chnl: chnl_d, y: {1'b0, py_d}, x: {1'b0, px_d}};
  end

  assign src_addr_c_o = ADDR_WIDTH'(SRC_BASE + ADDR_WIDTH'(src_off_c));
  assign dst_addr_c_o = ADDR_WIDTH'(DST_BASE + ADDR_WIDTH'(dst_off_c));

  // Counter and size registers.
  always_ff @(posedge clk) begin
    if (srst) begin
      nchnl_q <= '0;
      out_h_q <= '0;
      out_w_q <= '0;
      chnl_q  <= '0;
      py_q    <= '0;
      px_q    <= '0;
      win_q   <= '0;
    end else begin
      if (start_i) begin
        nchnl_q <= num_chnl_i;
        out_h_q <= out_h_i;
        out_w_q <= out_w_i;
      end
      chnl_q <= chnl_d;
      py_q   <= py_d;
      px_q   <= px_d;
      win_q  <= win_d;
    end
  end

endmodule

// File: rtl/pool_ctrl.sv
// 2x2 stride-2 max-pooling controller. Reads conv ofmap planes from SRC_BASE,
// writes one signed max per window to DST_BASE in the same {chnl, y, x} layout.
// Ports:
//   clk, srst          : clock, synchronous active-high reset
//   enable             : start pulse, sampled in IDLE only
//   num_chnl           : channel count (0..16), sampled at start
//   fmap_height/width  : ofmap size (0..32), sampled at start; odd tail dropped
//   done               : one-cycle completion pulse
//   dram               : DRAM read/write bundle (pool_ctrl_if.master)
// Optional: define POOL_RELU_EN to clamp negative results to 0 on write.
// All outputs are registered; output registers load from next-state decode so
// they align with the FSM state they belong to.
module pool_ctrl
  import pool_ctrl_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           ADDR_WIDTH = 18,
  parameter logic [ADDR_WIDTH-1:0] SRC_BASE   = ADDR_WIDTH'(OFMAP_BASE),
  parameter logic [ADDR_WIDTH-1:0] DST_BASE   = ADDR_WIDTH'(IFMAP_BASE)
) (
  input  logic               clk,
  input  logic               srst,
  input  logic               enable,
  input  logic [NCHNL_W-1:0] num_chnl,
  input  logic [FMAP_W-1:0]  fmap_height,
  input  logic [FMAP_W-1:0]  fmap_width,
  output logic               done,
  pool_ctrl_if.master        dram
);

  pool_state_e state_q, state_d;

  logic                  start_c, win_inc_c, adv_c, size_zero_c;
  logic [OUT_W-1:0]      out_h_c, out_w_c;
  logic                  unused_lsb_c;
  logic [WIN_W-1:0]      win_q;
  logic                  last_win_c, last_pix_c;
  logic [ADDR_WIDTH-1:0] src_addr_c, dst_addr_c;

  logic [DATA_WIDTH-1:0] max_q, max_d, wr_data_c;
  logic                  sample_gt_c;

  logic                  rd_en_q, rd_en_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] addr_in_q, addr_in_d;
  logic [ADDR_WIDTH-1:0] addr_out_q, addr_out_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  done_q, done_d;

  // Pooled size; an odd trailing row/column is simply dropped.
  assign out_h_c      = fmap_height[FMAP_W-1:1];
  assign out_w_c      = fmap_width[FMAP_W-1:1];
  assign unused_lsb_c = fmap_height[0] ^ fmap_width[0];
  assign size_zero_c  = (num_chnl == '0) || (out_h_c == '0) || (out_w_c == '0);

  pool_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .SRC_BASE   (SRC_BASE),
    .DST_BASE   (DST_BASE)
  ) u_addr_gen (
    .clk          (clk),
    .srst         (srst),
    .start_i      (start_c),
    .num_chnl_i   (num_chnl),
    .out_h_i      (out_h_c),
    .out_w_i      (out_w_c),
    .win_inc_i    (win_inc_c),
    .adv_i        (adv_c),
    .win_o        (win_q),
    .last_win_c_o (last_win_c),
    .last_pix_c_o (last_pix_c),
    .src_addr_c_o (src_addr_c),
    .dst_addr_c_o (dst_addr_c)
  );

  // Running window max. Data lags its address by one cycle, so sample k of a
  // window is seen while win_q == k+1, and sample 3 during ACC.
  assign sample_gt_c = $signed(dram.data_in) > $signed(max_q);

  always_comb begin
    max_d = max_q;
    if (state_q == S_RD && win_q == WIN_W'(1)) begin
      max_d = dram.data_in;
    end else if ((state_q == S_RD && win_q != WIN_W'(0)) || state_q == S_ACC) begin
      if (sample_gt_c) begin
        max_d = dram.data_in;
      end
    end
  end

`ifdef POOL_RELU_EN
  assign wr_data_c = max_d[DATA_WIDTH-1] ? '0 : max_d;
`else
  assign wr_data_c = max_d;
`endif

  // Next state, counter controls and next output values.
  always_comb begin
    state_d    = state_q;
    start_c    = 1'b0;
    win_inc_c  = 1'b0;
    adv_c      = 1'b0;
    rd_en_d    = 1'b0;
    wr_en_d    = 1'b0;
    addr_in_d  = '0;
    addr_out_d = '0;
    data_out_d = '0;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (enable) begin
          start_c = 1'b1;
          state_d = size_zero_c ? S_DONE : S_RD;
        end
      end
      S_RD: begin
        win_inc_c = 1'b1;
        if (last_win_c) begin
          state_d = S_ACC;
        end
      end
      S_ACC: begin
        state_d = S_WR;
      end
      S_WR: begin
        adv_c   = 1'b1;
        state_d = last_pix_c ? S_DONE : S_RD;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (state_d == S_RD) begin
      rd_en_d   = 1'b1;
      addr_in_d = src_addr_c;
    end
    if (state_d == S_WR) begin
      wr_en_d    = 1'b1;
      addr_out_d = dst_addr_c;
      data_out_d = wr_data_c;
    end
    done_d = (state_q == S_DONE);
  end

  // State, max and output registers.
  always_ff @(posedge clk) begin
    if (srst) begin
      state_q    <= S_IDLE;
      max_q      <= '0;
      rd_en_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      addr_in_q  <= '0;
      addr_out_q <= '0;
      data_out_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      max_q      <= max_d;
      rd_en_q    <= rd_en_d;
      wr_en_q    <= wr_en_d;
      addr_in_q  <= addr_in_d;
      addr_out_q <= addr_out_d;
      data_out_q <= data_out_d;
      done_q     <= done_d;
    end
  end

  assign dram.dram_en_rd = rd_en_q;
  assign dram.addr_in    = addr_in_q;
  assign dram.dram_en_wr = wr_en_q;
  assign dram.addr_out   = addr_out_q;
  assign dram.data_out   = data_out_q;
  assign done            = done_q;

endmodule

// File: tb/tb_pool_ctrl.sv
// Directed bench for pool_ctrl with a DRAM read model and a write scoreboard.
module tb_pool_ctrl;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 18;
  localparam int unsigned MEM_N = 16384;
  localparam logic [AW-1:0] SRC = 18'd131072;
  localparam logic [AW-1:0] DST = 18'd65536;

  logic       clk = 1'b0;
  logic       srst;
  logic       enable;
  logic [4:0] num_chnl;
  logic [5:0] fmap_height;
  logic [5:0] fmap_width;
  logic       done;

  pool_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dram_if ();

  pool_ctrl #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .SRC_BASE   (SRC),
    .DST_BASE   (DST)
  ) dut (
    .clk         (clk),
    .srst        (srst),
    .enable      (enable),
    .num_chnl    (num_chnl),
    .fmap_height (fmap_height),
    .fmap_width  (fmap_width),
    .done        (done),
    .dram        (dram_if)
  );

  always #5 clk = ~clk;

  // Source plane memory: offset {chnl[3:0], y[4:0], x[4:0]}.
  logic signed [DW-1:0] src_mem [MEM_N];

  // DRAM read model: data one cycle after the address; garbage otherwise.
  always @(posedge clk) begin
    if (dram_if.dram_en_rd) dram_if.data_in <= src_mem[dram_if.addr_in[13:0]];
    else                    dram_if.data_in <= 32'hDEAD_BEEF;
  end

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [13:0] idx(input int c, input int y, input int x);
    return 14'(c * 1024 + y * 32 + x);
  endfunction

  function automatic logic [DW-1:0] post(input logic signed [DW-1:0] m);
`ifdef POOL_RELU_EN
    return (m < 0) ? '0 : m;
`else
    return m;
`endif
  endfunction

  task automatic fill_random();
    for (int i = 0; i < int'(MEM_N); i++) src_mem[14'(i)] = $signed($urandom());
  endtask

  task automatic fill_ramp();
    fill_random();
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 4; x++) src_mem[idx(0, y, x)] = DW'(y * 4 + x);
  endtask

  // Runs one job. abort_at != 0 pulses srst at that cycle instead of
  // waiting for done.
  task automatic run_job(input string name, input int nc, input int h, input int w,
                         input bit hold, input int abort_at);
    int  oh, ow, exp_cyc, budget, cyc, writes, done_cyc;
    bit  seen_done, overlap, bad_idle, bad_rd;
    wr_t e;
    oh = h / 2;
    ow = w / 2;
    exp_cyc = 6 * nc * oh * ow + 2;
    budget  = (abort_at != 0) ? abort_at + 12 : exp_cyc + 40;
    writes = 0; done_cyc = 0; seen_done = 0;
    overlap = 0; bad_idle = 0; bad_rd = 0;

    exp_q.delete();
    for (int c = 0; c < nc; c++)
      for (int py = 0; py < oh; py++)
        for (int px = 0; px < ow; px++) begin
          logic signed [DW-1:0] m, v;
          m = src_mem[idx(c, 2*py, 2*px)];
          v = src_mem[idx(c, 2*py, 2*px+1)];   if (v > m) m = v;
          v = src_mem[idx(c, 2*py+1, 2*px)];   if (v > m) m = v;
          v = src_mem[idx(c, 2*py+1, 2*px+1)]; if (v > m) m = v;
          exp_q.push_back('{addr: AW'(DST + AW'(c * 1024 + py * 32 + px)), data: post(m)});
        end

    @(negedge clk);
    num_chnl    = 5'(nc);
    fmap_height = 6'(h);
    fmap_width  = 6'(w);
    enable      = 1'b1;

    cyc = 0;
    while (cyc < budget && !(seen_done && abort_at == 0)) begin
      cyc++;
      @(posedge clk);
      #1;
      if (!hold) enable = 1'b0;
      @(negedge clk);
      if (abort_at != 0 && cyc == abort_at + 1) begin
        check({name, " outputs after srst"},
              {dram_if.dram_en_rd, dram_if.dram_en_wr, done, dram_if.addr_in,
               dram_if.addr_out, dram_if.data_out}, 64'd0);
        srst = 1'b0;
      end
      if (dram_if.dram_en_rd && dram_if.dram_en_wr) overlap = 1'b1;
      if (!dram_if.dram_en_rd && dram_if.addr_in != '0) bad_idle = 1'b1;
      if (!dram_if.dram_en_wr && (dram_if.addr_out != '0 || dram_if.data_out != '0)) bad_idle = 1'b1;
      if (dram_if.dram_en_rd &&
          (dram_if.addr_in[17:14] != 4'b1000 || int'(dram_if.addr_in[13:10]) >= nc ||
           int'(dram_if.addr_in[9:5]) >= 2*oh || int'(dram_if.addr_in[4:0]) >= 2*ow))
        bad_rd = 1'b1;
      if (dram_if.dram_en_wr) begin
        writes++;
        if (exp_q.size() == 0) begin
          check({name, " unexpected write"}, 64'(dram_if.addr_out), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check({name, " write addr"}, 64'(dram_if.addr_out), 64'(e.addr));
          check({name, " write data"}, 64'(dram_if.data_out), 64'(e.data));
        end
      end
      if (done && !seen_done) begin
        seen_done = 1'b1;
        done_cyc  = cyc;
        enable    = 1'b0;
      end
      if (abort_at != 0 && cyc == abort_at) srst = 1'b1;
    end

    if (abort_at != 0) begin
      check({name, " no done after abort"}, 64'(seen_done), 64'd0);
      check({name, " writes before abort"}, 64'(writes), 64'((abort_at - 1) / 6));
    end else begin
      check({name, " done seen in budget"}, 64'(seen_done), 64'd1);
      check({name, " cycles to done"}, 64'(done_cyc), 64'(exp_cyc));
      check({name, " write count"}, 64'(writes), 64'(nc * oh * ow));
      check({name, " scoreboard empty"}, 64'(exp_q.size()), 64'd0);
      @(negedge clk);
      check({name, " single done pulse"},
            {done, dram_if.dram_en_rd, dram_if.dram_en_wr}, 64'd0);
    end
    check({name, " rd/wr never together"}, 64'(overlap), 64'd0);
    check({name, " idle outputs zero"}, 64'(bad_idle), 64'd0);
    check({name, " reads within window"}, 64'(bad_rd), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    srst = 1'b1; enable = 1'b0; num_chnl = '0; fmap_height = '0; fmap_width = '0;
    fill_random();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset outputs",
          {dram_if.dram_en_rd, dram_if.dram_en_wr, done, dram_if.addr_in,
           dram_if.addr_out, dram_if.data_out}, 64'd0);
    srst = 1'b0;
    @(negedge clk);

    fill_ramp();
    run_job("ramp4x4", 1, 4, 4, 1'b0, 0);

    fill_random();
    src_mem[idx(0, 0, 0)] = -32'sd8;
    src_mem[idx(0, 0, 1)] = -32'sd3;
    src_mem[idx(0, 1, 0)] = -32'sd5;
    src_mem[idx(0, 1, 1)] = -32'sd9;
    run_job("neg window", 1, 2, 2, 1'b0, 0);

    fill_random();
    run_job("odd5x3x2", 2, 5, 3, 1'b0, 0);
    run_job("zero chnl", 0, 4, 4, 1'b0, 0);
    run_job("width1", 2, 4, 1, 1'b0, 0);

    fill_ramp();
    run_job("abort", 1, 4, 4, 1'b0, 20);
    run_job("restart", 1, 4, 4, 1'b0, 0);

    fill_random();
    run_job("rand6x8x3", 3, 6, 8, 1'b0, 0);
    run_job("held32x32x2", 2, 32, 32, 1'b1, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
